// File: rtl/stack_unit_if.sv
// Controller handshake plus shared data-bus signals of the hardware stack engine.
// slave = stack engine side, master = controller/memory/arbiter side.
interface stack_unit_if;
    logic       stack_op_ongoing;
    logic       push_or_pop;
    logic       stack_op_end;
    logic [7:0] pc;
    logic [7:0] status_din;
    logic [7:0] return_addr;
    logic [7:0] status_dout;
    logic [7:0] sp;
    logic       bus_req;
    logic       bus_grant;
    logic [7:0] mem_addr;
    logic       mem_wr;
    logic       mem_rd;
    logic [7:0] mem_dout;
    logic [7:0] mem_din;
    logic       stack_ovf;
    logic       stack_unf;

    modport slave (
        input  stack_op_ongoing, push_or_pop, pc, status_din, bus_grant, mem_din,
        output stack_op_end, return_addr, status_dout, sp, bus_req,
               mem_addr, mem_wr, mem_rd, mem_dout, stack_ovf, stack_unf
    );

    modport master (
        output stack_op_ongoing, push_or_pop, pc, status_din, bus_grant, mem_din,
        input  stack_op_end, return_addr, status_dout, sp, bus_req,
               mem_addr, mem_wr, mem_rd, mem_dout, stack_ovf, stack_unf
    );
endinterface

// File: rtl/stack_unit.sv
// Stack engine: push saves {pc, status} to data memory, pop restores them; owns SP.
// Latency 4 cycles + grant wait + stall cycles (1 on a failed bounds check); a dropped grant stalls the access.
module stack_unit #(
    parameter logic [7:0] STACK_TOP   = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'hE0
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  sif
);

    typedef enum logic [2:0] {IDLE, ARB, ACC0, ACC1, DONE, HOLD} state_t;

    state_t     state_q, state_d;
    logic       op_push_q;
    logic [7:0] pc_q, st_q, sp_q, ret_q, sdo_q;
    logic       ovf_q, unf_q;
    logic       push_fail, pop_fail, chk_fail;
    logic       in_acc, xfer;

    // sp-1 < LIMIT rewritten as sp < LIMIT+1 so nothing underflows at sp=0
    assign push_fail = {1'b0, sp_q} < ({1'b0, STACK_LIMIT} + 9'd1);
    assign pop_fail  = ({1'b0, sp_q} + 9'd2) > {1'b0, STACK_TOP};
    assign chk_fail  = sif.push_or_pop ? push_fail : pop_fail;

    assign in_acc = (state_q == ACC0) || (state_q == ACC1);
    assign xfer   = in_acc && sif.bus_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_push_q <= 1'b0;
            pc_q      <= 8'h00;
            st_q      <= 8'h00;
            sp_q      <= STACK_TOP;
            ret_q     <= 8'h00;
            sdo_q     <= 8'h00;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && sif.stack_op_ongoing) begin
                op_push_q <= sif.push_or_pop;
                pc_q      <= sif.pc;
                st_q      <= sif.status_din;
                if (chk_fail) begin
                    if (sif.push_or_pop) ovf_q <= 1'b1;
                    else                 unf_q <= 1'b1;
                end
            end
            if (xfer && !op_push_q) begin
                if (state_q == ACC0) sdo_q <= sif.mem_din;
                else                 ret_q <= sif.mem_din;
            end
            if (xfer && state_q == ACC1)
                sp_q <= op_push_q ? sp_q - 8'd2 : sp_q + 8'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (sif.stack_op_ongoing) state_d = chk_fail ? DONE : ARB;
            ARB:  if (sif.bus_grant) state_d = ACC0;
            ACC0: if (sif.bus_grant) state_d = ACC1;
            ACC1: if (sif.bus_grant) state_d = DONE;
            DONE: state_d = HOLD;
            HOLD: if (!sif.stack_op_ongoing) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs come straight from the state register; strobes are gated by the live grant
    always_comb begin
        sif.mem_addr = 8'h00;
        sif.mem_dout = 8'h00;
        case (state_q)
            ACC0: begin
                sif.mem_addr = op_push_q ? sp_q : sp_q + 8'd1;
                sif.mem_dout = op_push_q ? pc_q : 8'h00;
            end
            ACC1: begin
                sif.mem_addr = op_push_q ? sp_q - 8'd1 : sp_q + 8'd2;
                sif.mem_dout = op_push_q ? st_q : 8'h00;
            end
            default: ;
        endcase
    end

    assign sif.bus_req      = (state_q == ARB) || in_acc;
    assign sif.mem_wr       = xfer && op_push_q;
    assign sif.mem_rd       = xfer && !op_push_q;
    assign sif.stack_op_end = (state_q == DONE);
    assign sif.sp           = sp_q;
    assign sif.return_addr  = ret_q;
    assign sif.status_dout  = sdo_q;
    assign sif.stack_ovf    = ovf_q;
    assign sif.stack_unf    = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: behavioural memory, scoreboard of expected bus
// transfers and per-operation results, immediate-assertion checks.
module tb_stack_unit;

    localparam logic [7:0] TOP = 8'hFF;
    localparam logic [7:0] LIM = 8'hE0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_unit_if bus ();

    stack_unit #(.STACK_TOP(TOP), .STACK_LIMIT(LIM)) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus)
    );

    logic [7:0]  mem  [256];
    logic [7:0]  mref [256];
    logic [18:0] obs_bus [$];

    assign bus.mem_din = mem[bus.mem_addr];

    always @(posedge clk)
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_dout;

    // Every strobe seen mid-cycle: {grant, wr, rd, addr, data}
    always @(negedge clk)
        if (rst && (bus.mem_wr || bus.mem_rd))
            obs_bus.push_back({bus.bus_grant, bus.mem_wr, bus.mem_rd, bus.mem_addr,
                               bus.mem_wr ? bus.mem_dout : bus.mem_din});

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_sp, m_ret, m_st;
    logic       m_ovf, m_unf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sp = TOP; m_ret = 8'h00; m_st = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {bus.sp, bus.return_addr, bus.status_dout, bus.stack_op_end, bus.bus_req,
                  bus.mem_wr, bus.mem_rd, bus.stack_ovf, bus.stack_unf, bus.mem_addr, bus.mem_dout},
                 {TOP, 16'h0000, 6'b000000, 16'h0000});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        bus.stack_op_ongoing = 1'b0;
        #2;
        chk_reset(tag);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One request: expectations are queued before driving, consumed when the DUT answers
    task automatic do_op(input bit push, input logic [7:0] p, input logic [7:0] s,
                         input logic [15:0] gmask, input int extra, input int hold,
                         input string tag);
        logic [18:0] eb [$];
        logic [25:0] er;
        logic [7:0]  a1, a2;
        bit          ok;
        int          k, lat, ends, e_lat;
        eb = {};
        if (push) begin
            ok = (int'(m_sp) - 1) >= int'(LIM);
            if (ok) begin
                a1 = m_sp;
                a2 = m_sp - 8'd1;
                eb.push_back({3'b110, a1, p});
                eb.push_back({3'b110, a2, s});
                mref[a1] = p;
                mref[a2] = s;
                m_sp = m_sp - 8'd2;
            end else m_ovf = 1'b1;
        end else begin
            ok = (int'(m_sp) + 2) <= int'(TOP);
            if (ok) begin
                a1 = m_sp + 8'd1;
                a2 = m_sp + 8'd2;
                eb.push_back({3'b101, a1, mref[a1]});
                eb.push_back({3'b101, a2, mref[a2]});
                m_st  = mref[a1];
                m_ret = mref[a2];
                m_sp  = m_sp + 8'd2;
            end else m_unf = 1'b1;
        end
        e_lat = ok ? 4 + extra : 1;
        er = {m_sp, m_ret, m_st, m_ovf, m_unf};
        obs_bus.delete();

        @(negedge clk);
        bus.stack_op_ongoing = 1'b1;
        bus.push_or_pop      = push;
        bus.pc               = p;
        bus.status_din       = s;
        bus.bus_grant        = gmask[0];
        k = 0; lat = -1; ends = 0;
        while (k < 60) begin
            @(posedge clk);
            #1;
            k++;
            bus.bus_grant = (k < 16) ? gmask[k] : 1'b1;
            if (k == 1) begin
                bus.pc         = ~p;
                bus.status_din = ~s;
            end
            @(negedge clk);
            if (bus.stack_op_end) begin
                ends++;
                if (lat < 0) begin
                    lat = k;
                    chk({tag, "_res"}, {bus.sp, bus.return_addr, bus.status_dout,
                                        bus.stack_ovf, bus.stack_unf}, er);
                end
            end
            if (lat >= 0 && k >= hold) break;
        end
        bus.stack_op_ongoing = 1'b0;
        chk({tag, "_lat"}, lat, e_lat);
        chk({tag, "_ends"}, ends, 1);
        chk({tag, "_nxfer"}, obs_bus.size(), eb.size());
        while (eb.size() > 0 && obs_bus.size() > 0)
            chk({tag, "_xfer"}, obs_bus.pop_front(), eb.pop_front());
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bus.stack_op_ongoing = 1'b0;
        bus.push_or_pop      = 1'b0;
        bus.pc               = 8'h00;
        bus.status_din       = 8'h00;
        bus.bus_grant        = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        do_op(1'b0, 8'h00, 8'h00, 16'hFFFF, 0, 0, "pop_empty");
        do_reset("reset_clears_flags");

        do_op(1'b1, 8'h3A, 8'h15, 16'hFFFF, 0, 0, "push1");
        chk("push1_memFF", mem[8'hFF], 8'h3A);
        chk("push1_memFE", mem[8'hFE], 8'h15);
        do_op(1'b0, 8'h00, 8'h00, 16'hFFFF, 0, 0, "pop1");

        // ARB cycles 1-3 without grant, grant dropped in first ACC1 cycle (6)
        do_op(1'b1, 8'h77, 8'h2A, 16'hFFB1, 4, 0, "push_stall");
        chk("stall_memFF", mem[8'hFF], 8'h77);
        chk("stall_memFE", mem[8'hFE], 8'h2A);
        do_op(1'b0, 8'h00, 8'h00, 16'hFFFF, 0, 0, "pop_stall");

        for (int i = 0; i < 16; i++)
            do_op(1'b1, 8'(i), 8'(i + 8'h40), 16'hFFFF, 0, 0, "push_fill");
        chk("fill_sp", bus.sp, 8'hDF);
        do_op(1'b1, 8'hEE, 8'hEE, 16'hFFFF, 0, 0, "push_ovf");

        do_op(1'b0, 8'h00, 8'h00, 16'hFFFF, 0, 10, "pop_held");

        // Reset asserted while a push sits in ACC0
        obs_bus.delete();
        @(negedge clk);
        bus.stack_op_ongoing = 1'b1;
        bus.push_or_pop      = 1'b1;
        bus.pc               = 8'h11;
        bus.status_din       = 8'h22;
        bus.bus_grant        = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_acc0_wr", {bus.bus_req, bus.mem_wr}, 2'b11);
        rst = 1'b0;
        #1;
        chk_reset("rst_mid_op");
        bus.stack_op_ongoing = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sp_after", bus.sp, TOP);
        chk("rst_nxfer", obs_bus.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
